muldiv_seq: RTL and testbench

Iterative, clocked multiply/divide/modulo unit parametrised in operand width. It is the sequential successor to the single-step combinational `mul`/`div`/`mod` ALU leaves, and it adds signed operation, a full double-width product, a remainder output and a start/busy/done handshake. It sits beside the ALU. The control path issues one operation and stalls writeback until `done`.

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 154 +++++++++++++++
 tb/tb_muldiv_seq.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master issues start/op/operands; the slave returns busy/done and results.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, op, sgn, a, b,
    input  busy, done, res, hi
  );

  modport slave (
    input  start, op, sgn, a, b,
    output busy, done, res, hi
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH
// accumulator; operates on magnitudes and fixes signs in a final cycle.
module muldiv_seq #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_MOD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic               sgn_eff;
  logic               last_iter;

  assign sgn_eff   = bus.sgn & SIGNED_EN;
  assign a_mag     = (sgn_eff && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (sgn_eff && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign last_iter = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // MUL keeps {partial product, remaining multiplier bits}; DIV keeps
  // {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  always_comb begin
    addend    = acc[0] ? operand : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    acc_step  = acc;
    if (op_q == OP_MUL)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_trial[WIDTH])
      acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {acc[2*WIDTH-2:0], 1'b0};
  end

  always_comb begin
    product = (a_neg ^ b_neg) ? -acc : acc;
    quot    = b_zero ? '1    : ((a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem     = b_zero ? a_raw : (a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);
    res_fix = '0;
    hi_fix  = '0;
    case (op_q)
      OP_MUL: begin
        res_fix = product[WIDTH-1:0];
        hi_fix  = product[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        res_fix = quot;
        hi_fix  = rem;
      end
      OP_MOD: begin
        res_fix = rem;
        hi_fix  = rem;
      end
      default: begin
        res_fix = '0;
        hi_fix  = '0;
      end
    endcase
  end

  // Sign flags already fold in the effective sign mode, so unsigned ops never negate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      op_q     <= OP_MUL;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      b_zero   <= 1'b0;
      a_raw    <= '0;
      operand  <= '0;
      acc      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.res  <= '0;
      bus.hi   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            a_neg    <= sgn_eff & bus.a[WIDTH-1];
            b_neg    <= sgn_eff & bus.b[WIDTH-1];
            b_zero   <= (bus.b == '0);
            a_raw    <= bus.a;
            operand  <= (bus.op == OP_MUL) ? a_mag : b_mag;
            acc      <= {{WIDTH{1'b0}}, (bus.op == OP_MUL) ? b_mag : a_mag};
            count    <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        FIX: begin
          bus.res  <= res_fix;
          bus.hi   <= hi_fix;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a 32-bit signed-capable unit plus two
// 8-bit units (SIGNED_EN=1/0) compared every cycle against an arithmetic model.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(32)) if32 ();
  muldiv_seq_if #(.WIDTH(8))  if8s ();
  muldiv_seq_if #(.WIDTH(8))  if8u ();

  assign if8u.start = if8s.start;
  assign if8u.op    = if8s.op;
  assign if8u.sgn   = if8s.sgn;
  assign if8u.a     = if8s.a;
  assign if8u.b     = if8s.b;

  muldiv_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32  (.clk(clk), .rst_n(rst_n), .bus(if32));
  muldiv_seq #(.WIDTH(8),  .SIGNED_EN(1'b1)) dut8s  (.clk(clk), .rst_n(rst_n), .bus(if8s));
  muldiv_seq #(.WIDTH(8),  .SIGNED_EN(1'b0)) dut8u  (.clk(clk), .rst_n(rst_n), .bus(if8u));

  // Per-channel model: ph = cycles since acceptance (0 idle, w+2 = done cycle).
  int          ph[3];
  logic [63:0] exp_res[3];
  logic [63:0] exp_hi[3];
  logic [63:0] last_res[3];
  logic [63:0] last_hi[3];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [127:0] refModel(input int w, input bit se, input logic [1:0] op,
                                            input logic sgn, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, am, bm, p, q, r, lo, hi;
    longint      sa, sb;
    bit          s;
    mask = (64'd1 << w) - 64'd1;
    am   = a & mask;
    bm   = b & mask;
    s    = sgn && se;
    sa   = longint'(am);
    sb   = longint'(bm);
    if (s && am[w-1]) sa = sa - longint'(64'd1 << w);
    if (s && bm[w-1]) sb = sb - longint'(64'd1 << w);
    lo = '0;
    hi = '0;
    q  = '0;
    r  = '0;
    p  = '0;
    case (op)
      2'd0: begin
        p  = 64'(sa * sb);
        lo = p & mask;
        hi = (p >> w) & mask;
      end
      2'd1, 2'd2: begin
        if (bm == 64'd0) begin
          q = mask;
          r = am;
        end else begin
          q = 64'(sa / sb) & mask;
          r = 64'(sa % sb) & mask;
        end
        lo = (op == 2'd1) ? q : r;
        hi = r;
      end
      default: ;
    endcase
    return {hi, lo};
  endfunction

  task automatic stepChannel(input int ch, input int w, input bit se, input logic st, input logic [1:0] op,
                             input logic sgn, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] r;
    if (ph[ch] == 0 || ph[ch] == w + 2) begin
      if (st) begin
        r           = refModel(w, se, op, sgn, a, b);
        exp_res[ch] = r[63:0];
        exp_hi[ch]  = r[127:64];
        ph[ch]      = 1;
      end else begin
        ph[ch] = 0;
      end
    end else begin
      ph[ch]++;
      if (ph[ch] == w + 2) begin
        last_res[ch] = exp_res[ch];
        last_hi[ch]  = exp_hi[ch];
      end
    end
  endtask

  task automatic cmpChannel(input int ch, input int w, input logic busy, input logic done,
                            input logic [63:0] res, input logic [63:0] hi);
    checkOutput($sformatf("ch%0d busy", ch), 64'(busy), 64'(ph[ch] >= 1 && ph[ch] <= w + 1));
    checkOutput($sformatf("ch%0d done", ch), 64'(done), 64'(ph[ch] == w + 2));
    checkOutput($sformatf("ch%0d res", ch), res, last_res[ch]);
    checkOutput($sformatf("ch%0d hi", ch), hi, last_hi[ch]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        ph[c]       = 0;
        last_res[c] = '0;
        last_hi[c]  = '0;
      end
    end else begin
      stepChannel(0, 32, 1'b1, if32.start, if32.op, if32.sgn, 64'(if32.a), 64'(if32.b));
      stepChannel(1, 8,  1'b1, if8s.start, if8s.op, if8s.sgn, 64'(if8s.a), 64'(if8s.b));
      stepChannel(2, 8,  1'b0, if8u.start, if8u.op, if8u.sgn, 64'(if8u.a), 64'(if8u.b));
    end
  end

  always @(negedge clk) begin
    cmpChannel(0, 32, if32.busy, if32.done, 64'(if32.res), 64'(if32.hi));
    cmpChannel(1, 8,  if8s.busy, if8s.done, 64'(if8s.res), 64'(if8s.hi));
    cmpChannel(2, 8,  if8u.busy, if8u.done, 64'(if8u.res), 64'(if8u.hi));
  end

  task automatic setInputs(input int grp, input logic st, input logic [1:0] op, input logic sgn,
                           input logic [63:0] a, input logic [63:0] b);
    if (grp == 0) begin
      if32.start = st;
      if32.op    = op;
      if32.sgn   = sgn;
      if32.a     = a[31:0];
      if32.b     = b[31:0];
    end else begin
      if8s.start = st;
      if8s.op    = op;
      if8s.sgn   = sgn;
      if8s.a     = a[7:0];
      if8s.b     = b[7:0];
    end
  endtask

  task automatic setStart(input int grp, input logic st);
    if (grp == 0) if32.start = st;
    else          if8s.start = st;
  endtask

  task automatic applyStimulus(input int grp, input logic [1:0] op, input logic sgn,
                               input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    setInputs(grp, 1'b1, op, sgn, a, b);
    @(posedge clk);
    #1;
    setStart(grp, 1'b0);
  endtask

  task automatic waitDone(input int grp, input int maxc, input bit scramble, output int lat);
    logic d;
    lat = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      d = (grp == 0) ? if32.done : if8s.done;
      if (d) begin
        lat = i;
        break;
      end
      if (scramble)
        setInputs(grp, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("[TB] FAIL done timeout grp%0d: got no done, expected one within %0d cycles", grp, maxc);
    end
  endtask

  function automatic logic [63:0] randVal(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return mask;
      3:       return 64'd1 << (w - 1);
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  initial begin
    logic [127:0] r;
    int           lat;
    bit           saw_done;

    rst_n = 1'b1;
    setInputs(0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    setInputs(1, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(if32.busy), 64'd0);
    checkOutput("reset done", 64'(if32.done), 64'd0);
    checkOutput("reset res", 64'(if32.res), 64'd0);
    checkOutput("reset hi", 64'(if32.hi), 64'd0);
    rst_n = 1'b1;

    // Hand-derived values pin the reference model itself.
    r = refModel(32, 1'b1, 2'd1, 1'b1, 64'hFFFF_FFF9, 64'd2);
    checkOutput("model sdiv res", r[63:0], 64'hFFFF_FFFD);
    checkOutput("model sdiv hi", r[127:64], 64'hFFFF_FFFF);
    r = refModel(8, 1'b1, 2'd0, 1'b1, 64'hFD, 64'h05);
    checkOutput("model smul8 hi", r[127:64], 64'hFF);
    r = refModel(8, 1'b0, 2'd0, 1'b1, 64'hFD, 64'h05);
    checkOutput("model umul8 hi", r[127:64], 64'h04);
    r = refModel(32, 1'b1, 2'd1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
    checkOutput("model ovf res", r[63:0], 64'h8000_0000);

    applyStimulus(0, 2'd0, 1'b0, 64'h0001_0000, 64'h0001_0000);
    waitDone(0, 100, 1'b0, lat);
    checkOutput("mul32 latency", 64'(lat), 64'd33);
    checkOutput("mul32 res", 64'(if32.res), 64'h0);
    checkOutput("mul32 hi", 64'(if32.hi), 64'h1);

    applyStimulus(0, 2'd1, 1'b1, 64'hFFFF_FFF9, 64'd2);
    waitDone(0, 100, 1'b0, lat);
    checkOutput("sdiv res", 64'(if32.res), 64'hFFFF_FFFD);
    checkOutput("sdiv hi", 64'(if32.hi), 64'hFFFF_FFFF);
    applyStimulus(0, 2'd2, 1'b1, 64'hFFFF_FFF9, 64'd2);
    waitDone(0, 100, 1'b0, lat);
    checkOutput("smod res", 64'(if32.res), 64'hFFFF_FFFF);
    applyStimulus(0, 2'd1, 1'b0, 64'hFFFF_FFF9, 64'd2);
    waitDone(0, 100, 1'b0, lat);
    checkOutput("udiv res", 64'(if32.res), 64'h7FFF_FFFC);
    checkOutput("udiv hi", 64'(if32.hi), 64'h1);
    applyStimulus(0, 2'd1, 1'b1, 64'h0000_1234, 64'd0);
    waitDone(0, 100, 1'b0, lat);
    checkOutput("div0 res", 64'(if32.res), 64'hFFFF_FFFF);
    checkOutput("div0 hi", 64'(if32.hi), 64'h1234);
    applyStimulus(0, 2'd1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
    waitDone(0, 100, 1'b0, lat);
    checkOutput("ovf res", 64'(if32.res), 64'h8000_0000);
    checkOutput("ovf hi", 64'(if32.hi), 64'h0);

    applyStimulus(1, 2'd0, 1'b1, 64'hFD, 64'h05);
    waitDone(1, 100, 1'b0, lat);
    checkOutput("mul8 latency", 64'(lat), 64'd9);
    checkOutput("smul8 res", 64'(if8s.res), 64'hF1);
    checkOutput("smul8 hi", 64'(if8s.hi), 64'hFF);
    checkOutput("umul8 res", 64'(if8u.res), 64'hF1);
    checkOutput("umul8 hi", 64'(if8u.hi), 64'h04);

    // Held start: second request is only taken in the done cycle.
    @(negedge clk);
    setInputs(0, 1'b1, 2'd0, 1'b0, 64'd3, 64'd4);
    @(posedge clk);
    #1;
    setInputs(0, 1'b1, 2'd0, 1'b0, 64'd9, 64'd9);
    waitDone(0, 100, 1'b0, lat);
    checkOutput("held first latency", 64'(lat), 64'd33);
    checkOutput("held first res", 64'(if32.res), 64'd12);
    @(posedge clk);
    #1;
    setStart(0, 1'b0);
    waitDone(0, 100, 1'b0, lat);
    checkOutput("held second latency", 64'(lat), 64'd33);
    checkOutput("held second res", 64'(if32.res), 64'd81);

    applyStimulus(0, 2'd0, 1'b0, 64'd7, 64'd6);
    repeat (5) @(posedge clk);
    #1;
    setInputs(0, 1'b0, 2'd1, 1'b1, 64'd100, 64'd1);
    waitDone(0, 100, 1'b0, lat);
    checkOutput("midrun change res", 64'(if32.res), 64'd42);
    checkOutput("midrun change hi", 64'(if32.hi), 64'd0);

    applyStimulus(0, 2'd0, 1'b0, 64'h1234, 64'h10);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(if32.busy), 64'd0);
    checkOutput("abort done", 64'(if32.done), 64'd0);
    checkOutput("abort res", 64'(if32.res), 64'd0);
    checkOutput("abort hi", 64'(if32.hi), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (if32.done) saw_done = 1'b1;
    end
    checkOutput("no done after abort", 64'(saw_done), 64'd0);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, 2'($urandom_range(0, 3)), 1'($urandom), randVal(32), randVal(32));
      waitDone(0, 100, 1'($urandom), lat);
      applyStimulus(1, 2'($urandom_range(0, 3)), 1'($urandom), randVal(8), randVal(8));
      waitDone(1, 100, 1'($urandom), lat);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
